// File: rtl/alu_seq_unit.sv
// Handshaked MIPS ALU with registered result and an iterative signed shift-add multiplier.
// Single-cycle ops complete in one cycle. MUL takes WIDTH+2 cycles from accept to Out_Valid.
module alu_seq_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [5:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             BranchTaken,
    output logic             IllegalOp
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam int CNT_W = SHAMT_W + 1;

    logic [1:0]         state_q, state_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    logic               br_q, br_d;
    logic               ill_q, ill_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;

    logic [WIDTH-1:0]   alu_res, a_abs, b_abs;
    logic [2*WIDTH-1:0] prod;
    logic               alu_br, alu_ill, is_mul, accept;

    assign In_Ready = (state_q == S_IDLE) & (~valid_q | Out_Ready);
    assign accept   = In_Valid & In_Ready;

    // Magnitudes as unsigned: negating -2^(WIDTH-1) yields 2^(WIDTH-1), which is the correct magnitude.
    assign a_abs = A[WIDTH-1] ? -A : A;
    assign b_abs = B[WIDTH-1] ? -B : B;
    assign prod  = sign_q ? -acc_q : acc_q;

    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        alu_ill = 1'b0;
        is_mul  = 1'b0;
        case (ALUControl)
            6'b100000: alu_res = A + B;
            6'b100010: alu_res = A - B;
            6'b011000: is_mul  = 1'b1;
            6'b100100: alu_res = A & B;
            6'b100101: alu_res = A | B;
            6'b100111: alu_res = ~(A | B);
            6'b100110: alu_res = A ^ B;
            6'b000000: alu_res = A << B[SHAMT_W-1:0];
            6'b000010: alu_res = A >> B[SHAMT_W-1:0];
            6'b101010: alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            6'b001000: alu_res = A;
            6'b000100: begin alu_res = A - B; alu_br = (A == B); end
            6'b000101: begin alu_res = A - B; alu_br = (A != B); end
            6'b000111: begin alu_res = A; alu_br = ~A[WIDTH-1] & (|A); end
            6'b000110: begin alu_res = A; alu_br = A[WIDTH-1] | ~(|A); end
            6'b000001: begin alu_res = A; alu_br = B[0] ? ~A[WIDTH-1] : A[WIDTH-1]; end
            default:   alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q & ~Out_Ready;
        res_d    = res_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        br_d     = br_q;
        ill_d    = ill_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_abs};
                    mplier_d = b_abs;
                    acc_d    = '0;
                    cnt_d    = CNT_W'(WIDTH);
                    sign_d   = A[WIDTH-1] ^ B[WIDTH-1];
                    state_d  = S_MUL;
                end else if (accept) begin
                    valid_d = 1'b1;
                    res_d   = alu_res;
                    hi_d    = '0;
                    zero_d  = (alu_res == '0);
                    br_d    = alu_br;
                    ill_d   = alu_ill;
                end
            end
            S_MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIN;
            end
            S_FIN: begin
                valid_d = 1'b1;
                res_d   = prod[WIDTH-1:0];
                hi_d    = prod[2*WIDTH-1:WIDTH];
                zero_d  = (prod[WIDTH-1:0] == '0);
                br_d    = 1'b0;
                ill_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            res_q    <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            br_q     <= 1'b0;
            ill_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            br_q     <= br_d;
            ill_q    <= ill_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
        end
    end

    assign Out_Valid   = valid_q;
    assign ALUResult   = res_q;
    assign ResultHi    = hi_q;
    assign Zero        = zero_q;
    assign BranchTaken = br_q;
    assign IllegalOp   = ill_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed cases, randomized ops against an arithmetic model,
// back-to-back, backpressure and mid-multiply reset.
module tb_alu_seq_unit;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst, In_Valid, In_Ready, Out_Valid, Out_Ready;
    logic         Zero, BranchTaken, IllegalOp;
    logic [5:0]   ALUControl;
    logic [W-1:0] A, B, ALUResult, ResultHi;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    alu_seq_unit #(.WIDTH(W), .SHAMT_W(5)) dut (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .ALUControl(ALUControl), .A(A), .B(B), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .ALUResult(ALUResult), .ResultHi(ResultHi), .Zero(Zero),
        .BranchTaken(BranchTaken), .IllegalOp(IllegalOp)
    );

    // Reference model: plain signed/unsigned arithmetic, 64-bit product for MUL.
    function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic br, output logic ill, output int lat);
        longint p;
        int sa, sb;
        sa = a; sb = b;
        lo = 0; hi = 0; br = 0; ill = 0; lat = 1;
        case (op)
            6'b100000: lo = a + b;
            6'b100010: lo = a - b;
            6'b011000: begin p = longint'(sa) * longint'(sb); lo = p[31:0]; hi = p[63:32]; lat = W + 2; end
            6'b100100: lo = a & b;
            6'b100101: lo = a | b;
            6'b100111: lo = ~(a | b);
            6'b100110: lo = a ^ b;
            6'b000000: lo = a << b[4:0];
            6'b000010: lo = a >> b[4:0];
            6'b101010: lo = (sa < sb) ? 1 : 0;
            6'b001000: lo = a;
            6'b000100: begin lo = a - b; br = (a == b); end
            6'b000101: begin lo = a - b; br = (a != b); end
            6'b000111: begin lo = a; br = (sa > 0); end
            6'b000110: begin lo = a; br = (sa <= 0); end
            6'b000001: begin lo = a; br = b[0] ? (sa >= 0) : (sa < 0); end
            default:   ill = 1;
        endcase
    endfunction

    function automatic logic [5:0] legal_code(input int i);
        case (i)
            0: return 6'b100000;  1: return 6'b100010;  2: return 6'b100100;  3: return 6'b100101;
            4: return 6'b100111;  5: return 6'b100110;  6: return 6'b000000;  7: return 6'b000010;
            8: return 6'b101010;  9: return 6'b001000; 10: return 6'b000100; 11: return 6'b000101;
           12: return 6'b000111; 13: return 6'b000110; 14: return 6'b000001;
            default: return 6'b011000;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Presents one op, waits for acceptance, then counts cycles until Out_Valid.
    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int lowcnt);
        int n;
        ALUControl = op; A = a; B = b; In_Valid = 1'b1;
        n = 0;
        while (!In_Ready && n < 50) begin @(posedge Clk); #1; n++; end
        if (!In_Ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: In_Ready=%0b required 1", In_Ready);
        end
        @(posedge Clk); #1;
        In_Valid = 1'b0; ALUControl = 6'($urandom); A = $urandom; B = $urandom;
        lat = 1; lowcnt = 0;
        while (!Out_Valid && lat < 100) begin
            if (!In_Ready) lowcnt++;
            @(posedge Clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1; ALUControl = '0; A = '0; B = '0;
        repeat (2) @(posedge Clk);
        #1;
        total++;
        if ({Out_Valid, ALUResult, ResultHi, Zero, BranchTaken, IllegalOp} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%0b r=%h hi=%h z=%0b br=%0b ill=%0b required all 0",
                     Out_Valid, ALUResult, ResultHi, Zero, BranchTaken, IllegalOp);
        end
        Rst = 1'b1;
        @(posedge Clk); #1;
        total++;
        if (In_Ready !== 1'b1) begin bad++; $display("FAIL reset_ready: In_Ready=%0b required 1", In_Ready); end
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, lo;
        logic        br, ill;
    } dir_t;

    task automatic test_directed();
        dir_t tbl[12];
        int lat, low;
        tbl[0]  = '{6'b101010, 32'hFFFF_FFFF, 32'd1,        32'd1,          1'b0, 1'b0};
        tbl[1]  = '{6'b000010, 32'h8000_0000, 32'd31,       32'd1,          1'b0, 1'b0};
        tbl[2]  = '{6'b000000, 32'd1,         32'h25,       32'h20,         1'b0, 1'b0};
        tbl[3]  = '{6'b000001, 32'd0,         32'd1,        32'd0,          1'b1, 1'b0};
        tbl[4]  = '{6'b000001, 32'h8000_0000, 32'd0,        32'h8000_0000,  1'b1, 1'b0};
        tbl[5]  = '{6'b000101, 32'd3,         32'd3,        32'd0,          1'b0, 1'b0};
        tbl[6]  = '{6'b000110, 32'd1,         32'd0,        32'd1,          1'b0, 1'b0};
        tbl[7]  = '{6'b000100, 32'd9,         32'd9,        32'd0,          1'b1, 1'b0};
        tbl[8]  = '{6'b000111, 32'h7FFF_FFFF, 32'd0,        32'h7FFF_FFFF,  1'b1, 1'b0};
        tbl[9]  = '{6'b001000, 32'h1234_5678, 32'hFFFF,     32'h1234_5678,  1'b0, 1'b0};
        tbl[10] = '{6'b100111, 32'd0,         32'd0,        32'hFFFF_FFFF,  1'b0, 1'b0};
        tbl[11] = '{6'b111110, 32'd5,         32'd6,        32'd0,          1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, low);
            total++;
            if (lat !== 1 || ALUResult !== tbl[i].lo || ResultHi !== 32'd0 || Zero !== (tbl[i].lo == 0) ||
                BranchTaken !== tbl[i].br || IllegalOp !== tbl[i].ill) begin
                bad++;
                $display("FAIL directed_%0d op=%b: got lat=%0d r=%h hi=%h z=%0b br=%0b ill=%0b required lat=1 r=%h hi=0 z=%0b br=%0b ill=%0b",
                         i, tbl[i].op, lat, ALUResult, ResultHi, Zero, BranchTaken, IllegalOp,
                         tbl[i].lo, (tbl[i].lo == 0), tbl[i].br, tbl[i].ill);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] elo, ehi;
        logic        ebr, eill;
        int          elat;
        logic [5:0]  op;
        logic [31:0] a, b;
        ALUControl = 6'b100000; A = 32'd5; B = 32'd7; In_Valid = 1'b1;
        @(posedge Clk); #1;
        total++;
        if (Out_Valid !== 1'b1 || ALUResult !== 32'd12 || Zero !== 1'b0 || In_Ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_add: got v=%0b r=%h z=%0b rdy=%0b required v=1 r=0000000c z=0 rdy=1",
                     Out_Valid, ALUResult, Zero, In_Ready);
        end
        ALUControl = 6'b100010; A = 32'd7; B = 32'd7;
        @(posedge Clk); #1;
        total++;
        if (Out_Valid !== 1'b1 || ALUResult !== 32'd0 || Zero !== 1'b1) begin
            bad++;
            $display("FAIL b2b_sub: got v=%0b r=%h z=%0b required v=1 r=0 z=1", Out_Valid, ALUResult, Zero);
        end
        for (int i = 0; i < 8; i++) begin
            op = legal_code($urandom_range(0, 14)); a = pick_operand(); b = pick_operand();
            model(op, a, b, elo, ehi, ebr, eill, elat);
            ALUControl = op; A = a; B = b;
            @(posedge Clk); #1;
            total++;
            if (Out_Valid !== 1'b1 || ALUResult !== elo || Zero !== (elo == 0) || BranchTaken !== ebr) begin
                bad++;
                $display("FAIL b2b_chain_%0d op=%b: got v=%0b r=%h z=%0b br=%0b required v=1 r=%h z=%0b br=%0b",
                         i, op, Out_Valid, ALUResult, Zero, BranchTaken, elo, (elo == 0), ebr);
            end
        end
        In_Valid = 1'b0;
    endtask

    task automatic test_mul();
        int lat, low;
        do_op(6'b011000, 32'hFFFF_FFFF, 32'd2, lat, low);
        total++;
        if (lat !== W + 2 || low !== W + 1 || ALUResult !== 32'hFFFF_FFFE || ResultHi !== 32'hFFFF_FFFF || Zero !== 1'b0) begin
            bad++;
            $display("FAIL mul_neg1x2: got lat=%0d low=%0d lo=%h hi=%h z=%0b required lat=%0d low=%0d lo=fffffffe hi=ffffffff z=0",
                     lat, low, ALUResult, ResultHi, Zero, W + 2, W + 1);
        end
        do_op(6'b011000, 32'h8000_0000, 32'h8000_0000, lat, low);
        total++;
        if (lat !== W + 2 || ALUResult !== 32'd0 || ResultHi !== 32'h4000_0000 || Zero !== 1'b1) begin
            bad++;
            $display("FAIL mul_minxmin: got lat=%0d lo=%h hi=%h z=%0b required lat=%0d lo=0 hi=40000000 z=1",
                     lat, ALUResult, ResultHi, Zero, W + 2);
        end
    endtask

    task automatic test_random();
        logic [31:0] elo, ehi, a, b;
        logic        ebr, eill;
        int          elat, lat, low;
        logic [5:0]  op;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = legal_code($urandom_range(0, 16));
            a = pick_operand(); b = pick_operand();
            model(op, a, b, elo, ehi, ebr, eill, elat);
            do_op(op, a, b, lat, low);
            total++;
            if (lat !== elat || ALUResult !== elo || ResultHi !== ehi || Zero !== (elo == 0) ||
                BranchTaken !== ebr || IllegalOp !== eill) begin
                bad++;
                $display("FAIL random_%0d op=%b a=%h b=%h: got lat=%0d lo=%h hi=%h z=%0b br=%0b ill=%0b required lat=%0d lo=%h hi=%h z=%0b br=%0b ill=%0b",
                         i, op, a, b, lat, ALUResult, ResultHi, Zero, BranchTaken, IllegalOp,
                         elat, elo, ehi, (elo == 0), ebr, eill);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] elo, ehi, xlo;
        logic        ebr, eill;
        int          elat, lat, low;
        @(posedge Clk); #1;
        Out_Ready = 1'b0;
        model(6'b100000, 32'd100, 32'd23, elo, ehi, ebr, eill, elat);
        do_op(6'b100000, 32'd100, 32'd23, lat, low);
        model(6'b100110, 32'h0000_F0F0, 32'h0000_0FF0, xlo, ehi, ebr, eill, elat);
        ALUControl = 6'b100110; A = 32'h0000_F0F0; B = 32'h0000_0FF0; In_Valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            total++;
            if (Out_Valid !== 1'b1 || ALUResult !== elo || Zero !== 1'b0 || In_Ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold_%0d: got v=%0b r=%h z=%0b rdy=%0b required v=1 r=%h z=0 rdy=0",
                         i, Out_Valid, ALUResult, Zero, In_Ready, elo);
            end
        end
        Out_Ready = 1'b1;
        #1;
        total++;
        if (In_Ready !== 1'b1) begin bad++; $display("FAIL release_ready: In_Ready=%0b required 1", In_Ready); end
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        total++;
        if (Out_Valid !== 1'b1 || ALUResult !== xlo) begin
            bad++;
            $display("FAIL pending_xor: got v=%0b r=%h required v=1 r=%h", Out_Valid, ALUResult, xlo);
        end
        @(posedge Clk); #1;
        total++;
        if (Out_Valid !== 1'b0) begin bad++; $display("FAIL drain_clear: Out_Valid=%0b required 0", Out_Valid); end
    endtask

    task automatic test_reset_mid_mul();
        int lat, low, stray;
        ALUControl = 6'b011000; A = 32'hFFFF_FFF3; B = 32'h0000_0777; In_Valid = 1'b1;
        total++;
        if (In_Ready !== 1'b1) begin bad++; $display("FAIL mul_issue_ready: In_Ready=%0b required 1", In_Ready); end
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        Rst = 1'b0;
        #1;
        total++;
        if ({Out_Valid, ALUResult, ResultHi, Zero, BranchTaken, IllegalOp} !== '0) begin
            bad++;
            $display("FAIL midmul_reset: got v=%0b r=%h hi=%h z=%0b br=%0b ill=%0b required all 0",
                     Out_Valid, ALUResult, ResultHi, Zero, BranchTaken, IllegalOp);
        end
        #2;
        Rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk); #1;
            if (Out_Valid !== 1'b0) stray++;
        end
        total++;
        if (stray !== 0 || In_Ready !== 1'b1) begin
            bad++;
            $display("FAIL abandoned_mul: got stray_valid_cycles=%0d rdy=%0b required 0 and 1", stray, In_Ready);
        end
        do_op(6'b111111, 32'h1234, 32'h5678, lat, low);
        total++;
        if (lat !== 1 || IllegalOp !== 1'b1 || ALUResult !== 32'd0 || Zero !== 1'b1 || BranchTaken !== 1'b0) begin
            bad++;
            $display("FAIL illegal_op: got lat=%0d ill=%0b r=%h z=%0b br=%0b required lat=1 ill=1 r=0 z=1 br=0",
                     lat, IllegalOp, ALUResult, Zero, BranchTaken);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_mul();
        test_random();
        test_backpressure();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
